// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: widths, the NOP word, fetch FSM states and the IF/ID record.
package mips_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned ADDR_W  = 32;

    // sll $0,$0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD
    } fetch_state_t;

    typedef struct packed {
        logic               valid;
        logic [ADDR_W-1:0]  pc4;
        logic [INSTR_W-1:0] instr;
    } ifid_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/grant/response bus between fetch and the memory.
interface fetch_stage_if;
    import mips_pkg::*;

    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               gnt;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register. Priority: flush > hold > load; otherwise the entry is consumed.
module ifid_reg
    import mips_pkg::*;
#(
    parameter logic [INSTR_W-1:0] NOP_WORD = NOP_INSTR
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  flush,
    input  logic  hold,
    input  logic  load,
    input  ifid_t load_data,
    output ifid_t ifid
);

    // Register update; an unloaded, unheld entry becomes a bubble (payload kept).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ifid <= '{valid: 1'b0, pc4: '0, instr: NOP_WORD};
        end else if (flush) begin
            ifid <= '{valid: 1'b0, pc4: '0, instr: NOP_WORD};
        end else if (hold) begin
            ifid <= ifid;
        end else if (load) begin
            ifid <= load_data;
        end else begin
            ifid.valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC, imem handshake, IF/ID register, stall and redirect.
// Optional macro FETCH_PERF_CNT_EN adds perf_fetched / perf_stall_cyc / perf_flush counters.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = mips_pkg::NOP_INSTR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fetch_stage_if.master        imem,
    input  logic                 id_stall,
    input  logic                 redirect_valid,
    input  logic [31:0]          redirect_pc,
    output logic                 ifid_valid,
    output logic [31:0]          ifid_pc4,
    output logic [31:0]          ifid_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]          perf_fetched,
    output logic [31:0]          perf_stall_cyc,
    output logic [31:0]          perf_flush,
`endif
    output logic [31:0]          fetch_pc
);

    fetch_state_t state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         kill_q, kill_d;
    logic [31:0]  hold_pc4_q, hold_pc4_d;
    logic [31:0]  hold_instr_q, hold_instr_d;

    ifid_t ifid;
    ifid_t load_data;
    logic  ifid_load;
    logic  req;
    logic  accept;
    logic  unused_pc_bits;

    assign unused_pc_bits = ^redirect_pc[1:0];

    // IF/ID can take a new entry when decode is not stalled or the slot is a bubble.
    assign accept = !id_stall || !ifid.valid;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            kill_q       <= 1'b0;
            hold_pc4_q   <= '0;
            hold_instr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            kill_q       <= kill_d;
            hold_pc4_q   <= hold_pc4_d;
            hold_instr_q <= hold_instr_d;
        end
    end

    // Next-state: redirect beats everything; a still-outstanding response gets killed.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        kill_d       = kill_q;
        hold_pc4_d   = hold_pc4_q;
        hold_instr_d = hold_instr_q;
        if (redirect_valid) begin
            pc_d         = {redirect_pc[31:2], 2'b00};
            hold_pc4_d   = '0;
            hold_instr_d = '0;
            if (state_q == S_WAIT && !imem.rvalid) begin
                state_d = S_WAIT;
                kill_d  = 1'b1;
            end else begin
                state_d = S_REQ;
                kill_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                S_REQ: begin
                    if (imem.gnt) begin
                        state_d  = S_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                    end
                end
                S_WAIT: begin
                    if (imem.rvalid) begin
                        if (kill_q) begin
                            kill_d  = 1'b0;
                            state_d = S_REQ;
                        end else if (accept) begin
                            // Back-to-back: the next request goes out with this response.
                            if (imem.gnt) begin
                                req_pc_d = pc_q;
                                pc_d     = pc_q + 32'd4;
                            end else begin
                                state_d = S_REQ;
                            end
                        end else begin
                            hold_pc4_d   = req_pc_q + 32'd4;
                            hold_instr_d = imem.rdata;
                            state_d      = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        state_d = S_REQ;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end
    end

    // Outputs: memory request and the IF/ID load source.
    always_comb begin
        req       = 1'b0;
        ifid_load = 1'b0;
        load_data = '{valid: 1'b1, pc4: req_pc_q + 32'd4, instr: imem.rdata};
        if (!redirect_valid) begin
            unique case (state_q)
                S_REQ: req = 1'b1;
                S_WAIT: begin
                    if (imem.rvalid && !kill_q && accept) begin
                        req       = 1'b1;
                        ifid_load = 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) begin
                        ifid_load = 1'b1;
                        load_data = '{valid: 1'b1, pc4: hold_pc4_q, instr: hold_instr_q};
                    end
                end
                default: req = 1'b0;
            endcase
        end
        imem.req  = req && rst_n;
        imem.addr = pc_q;
    end

    ifid_reg #(
        .NOP_WORD (NOP_INSTR)
    ) u_ifid_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (redirect_valid),
        .hold      (id_stall && ifid.valid),
        .load      (ifid_load),
        .load_data (load_data),
        .ifid      (ifid)
    );

    assign ifid_valid = ifid.valid;
    assign ifid_pc4   = ifid.pc4;
    assign ifid_instr = ifid.instr;
    assign fetch_pc   = pc_q;

`ifdef FETCH_PERF_CNT_EN
    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetched   <= '0;
            perf_stall_cyc <= '0;
            perf_flush     <= '0;
        end else begin
            if (ifid_load && !redirect_valid) perf_fetched <= perf_fetched + 32'd1;
            if (ifid.valid && id_stall)       perf_stall_cyc <= perf_stall_cyc + 32'd1;
            if (redirect_valid)               perf_flush <= perf_flush + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;
    import mips_pkg::*;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if imem_bus ();
    logic        id_stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        ifid_valid;
    logic [31:0] ifid_pc4;
    logic [31:0] ifid_instr;
    logic [31:0] fetch_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush;
`endif

    fetch_stage #(
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem           (imem_bus.master),
        .id_stall       (id_stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ifid_valid     (ifid_valid),
        .ifid_pc4       (ifid_pc4),
        .ifid_instr     (ifid_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched   (perf_fetched),
        .perf_stall_cyc (perf_stall_cyc),
        .perf_flush     (perf_flush),
`endif
        .fetch_pc       (fetch_pc)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Memory side: one outstanding fetch, answered after a chosen delay.
    bit          mem_pending;
    int unsigned mem_wait;
    logic [31:0] mem_addr;

    // Reference model: fetch pointer, the in-flight fetch, a parked word and IF/ID contents.
    logic [31:0] m_pc;
    bit          m_busy;
    bit          m_kill;
    logic [31:0] m_req_addr;
    bit          m_park;
    logic [31:0] m_park_pc4;
    logic [31:0] m_park_instr;
    bit          m_if_valid;
    logic [31:0] m_if_pc4;
    logic [31:0] m_if_instr;
    bit          m_exact;
    int unsigned m_fetched;
    int unsigned m_stalls;
    int unsigned m_flushes;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc       = RST_PC;
        m_busy     = 1'b0;
        m_kill     = 1'b0;
        m_park     = 1'b0;
        m_if_valid = 1'b0;
        m_if_pc4   = 32'h0;
        m_if_instr = NOP_INSTR;
        m_exact    = 1'b1;
        m_fetched  = 0;
        m_stalls   = 0;
        m_flushes  = 0;
    endtask

    // A request is presented only when fetch is idle, or a live response is being accepted.
    function automatic bit model_req(input bit rv, input bit redir, input bit stall);
        if (redir || m_park) return 1'b0;
        if (!m_busy) return 1'b1;
        return rv && !m_kill && (!stall || !m_if_valid);
    endfunction

    task automatic model_step(input bit stall, input bit redir, input logic [31:0] rpc,
                              input bit gnt, input bit rv);
        bit accept;
        bit keep;
        bit req;
        bit loaded;
        accept = !stall || !m_if_valid;
        keep   = stall && m_if_valid;
        req    = model_req(rv, redir, stall);
        loaded = 1'b0;
        if (keep) m_stalls++;
        if (redir) begin
            m_flushes++;
            m_if_valid = 1'b0;
            m_if_pc4   = 32'h0;
            m_if_instr = NOP_INSTR;
            m_exact    = 1'b1;
            m_pc       = {rpc[31:2], 2'b00};
            m_park     = 1'b0;
            if (m_busy && !rv) begin
                m_kill = 1'b1;
            end else begin
                m_busy = 1'b0;
                m_kill = 1'b0;
            end
        end else begin
            if (m_park) begin
                if (accept) begin
                    m_if_pc4   = m_park_pc4;
                    m_if_instr = m_park_instr;
                    m_park     = 1'b0;
                    loaded     = 1'b1;
                end
            end else if (m_busy && rv) begin
                m_busy = 1'b0;
                if (m_kill) begin
                    m_kill = 1'b0;
                end else if (accept) begin
                    m_if_pc4   = m_req_addr + 32'd4;
                    m_if_instr = mem_word(m_req_addr);
                    loaded     = 1'b1;
                end else begin
                    m_park       = 1'b1;
                    m_park_pc4   = m_req_addr + 32'd4;
                    m_park_instr = mem_word(m_req_addr);
                end
            end
            if (req && gnt) begin
                m_busy     = 1'b1;
                m_req_addr = m_pc;
                m_pc       = m_pc + 32'd4;
            end
            if (loaded) begin
                m_if_valid = 1'b1;
                m_exact    = 1'b0;
                m_fetched++;
            end else if (!keep) begin
                m_if_valid = 1'b0;
            end
        end
    endtask

    task automatic check_state();
        check("ifid_valid", 32'(ifid_valid), 32'(m_if_valid));
        check("fetch_pc", fetch_pc, m_pc);
        if (m_if_valid || m_exact) begin
            check("ifid_pc4", ifid_pc4, m_if_pc4);
            check("ifid_instr", ifid_instr, m_if_instr);
        end
`ifdef FETCH_PERF_CNT_EN
        check("perf_fetched", perf_fetched, m_fetched);
        check("perf_stall_cyc", perf_stall_cyc, m_stalls);
        check("perf_flush", perf_flush, m_flushes);
`endif
    endtask

    // One clock: entered and left at posedge+1.
    task automatic run_cycle(input bit stall, input bit redir, input logic [31:0] rpc,
                             input bit gnt, input int unsigned dly, input bit force_rv);
        bit          rv;
        bit          mem_rv;
        bit          took;
        logic [31:0] a;
        mem_rv = 1'b0;
        if (mem_pending) begin
            mem_wait--;
            if (mem_wait == 0) mem_rv = 1'b1;
        end
        rv = mem_rv || force_rv;
        id_stall         = stall;
        redirect_valid   = redir;
        redirect_pc      = rpc;
        imem_bus.gnt     = gnt;
        imem_bus.rvalid  = rv;
        imem_bus.rdata   = mem_rv ? mem_word(mem_addr) : $urandom;
        #2;
        check("imem_req", 32'(imem_bus.req), 32'(model_req(rv, redir, stall)));
        if (imem_bus.req) check("imem_addr", imem_bus.addr, m_pc);
        took = imem_bus.req && gnt;
        a    = imem_bus.addr;
        @(posedge clk);
        model_step(stall, redir, rpc, gnt, rv);
        if (mem_rv) mem_pending = 1'b0;
        if (took) begin
            mem_pending = 1'b1;
            mem_wait    = dly;
            mem_addr    = a;
        end
        #1;
        check_state();
    endtask

    task automatic async_reset();
        #3;
        id_stall        = 1'b0;
        redirect_valid  = 1'b0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        rst_n           = 1'b0;
        #1;
        model_reset();
        mem_pending = 1'b0;
        check("rst_req", 32'(imem_bus.req), 32'h0);
        check_state();
        @(posedge clk);
        #1;
        check("rst_req_held", 32'(imem_bus.req), 32'h0);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        id_stall        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_bus.gnt    = 1'b0;
        imem_bus.rvalid = 1'b0;
        imem_bus.rdata  = 32'h0;
        mem_pending     = 1'b0;
        mem_wait        = 0;
        mem_addr        = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req", 32'(imem_bus.req), 32'h0);
        check("reset_pc", fetch_pc, RST_PC);
        check_state();
        rst_n = 1'b1;

        // Streaming across the 2^32 wrap: one instruction per cycle.
        repeat (20) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        check("stream_valid", 32'(ifid_valid), 32'h1);

        // Stall while responses arrive: park, then resume without loss.
        repeat (3) run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        repeat (5) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Redirect while a slow response is outstanding.
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        run_cycle(1'b0, 1'b1, 32'h0000_0103, 1'b1, 1, 1'b0);
        check("redir_pc", fetch_pc, 32'h0000_0100);
        check("redir_flush", 32'(ifid_valid), 32'h0);
        repeat (6) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Redirect together with stall: flush wins.
        run_cycle(1'b1, 1'b0, 32'h0, 1'b1, 1, 1'b0);
        run_cycle(1'b1, 1'b1, 32'h0000_2000, 1'b1, 1, 1'b0);
        check("stall_flush_valid", 32'(ifid_valid), 32'h0);
        check("stall_flush_instr", ifid_instr, NOP_INSTR);

        // Reset mid-transaction, then a stale response that must be ignored.
        repeat (2) run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b0);
        run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 3, 1'b0);
        async_reset();
        run_cycle(1'b0, 1'b0, 32'h0, 1'b0, 1, 1'b1);
        check("post_rst_addr", imem_bus.addr, RST_PC);
        repeat (10) run_cycle(1'b0, 1'b0, 32'h0, 1'b1, 1, 1'b0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] rpc;
            rpc = ($urandom % 4 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            run_cycle(($urandom % 4) == 0, ($urandom % 15) == 0, rpc,
                      ($urandom % 3) != 0, $urandom_range(1, 3), 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline. Sits directly upstream of decode.
- Owns the PC register and drives a request/grant/response interface to instruction memory.
- Produces the IF/ID pipeline register (valid, PC+4, instruction) consumed by decode.
- Honours the hazard-unit stall and EX-stage branch/jump redirects, with flush.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSTR, 32'h0000_0000, instruction word driven into IF/ID on reset or flush (sll $0,$0,0).

Ports:
clk  input  1  pipeline clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch byte address; bits [1:0] always 0
imem_gnt  input  1  memory accepts the request this cycle (handshake with imem_req)
imem_rvalid  input  1  response valid; at most one outstanding; arrives >=1 cycle after grant
imem_rdata  input  32  instruction word, valid with imem_rvalid
id_stall  input  1  decode cannot accept; IF/ID must hold
redirect_valid  input  1  taken branch/jump resolved in EX
redirect_pc  input  32  redirect target; bits [1:0] ignored
ifid_valid  output  1  IF/ID holds a real instruction
ifid_pc4  output  32  PC+4 of the IF/ID instruction
ifid_instr  output  32  IF/ID instruction word
fetch_pc  output  32  current PC register (debug/trace)

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=S_REQ, ifid_valid=0, ifid_pc4=0, ifid_instr=NOP_INSTR, hold buffer empty, kill flag clear. imem_req is 0 while rst_n=0.
- FSM states:
  - S_REQ: imem_req=1, imem_addr=pc.
    - gnt: go to S_WAIT; record req_pc=pc; pc<=pc+4.
  - S_WAIT: waiting for imem_rvalid.
    - rvalid and IF/ID can accept (!id_stall or !ifid_valid): load IF/ID {1, req_pc+4, rdata}.
    - In that same cycle imem_req=1 with imem_addr=pc (back-to-back). gnt: stay in S_WAIT; otherwise go to S_REQ.
    - rvalid with IF/ID unable to accept: store rdata/req_pc in the hold buffer, go to S_HOLD, no new request.
  - S_HOLD: imem_req=0. When stall drops, move the hold buffer into IF/ID and go to S_REQ.
- Throughput: one instruction per cycle when gnt is immediate and rvalid arrives the cycle after grant. Latency from req accept to ifid_valid: 2 edges minimum.
- id_stall with ifid_valid=1: ifid_* hold unchanged. id_stall with ifid_valid=0 is ignored (bubble may be overwritten).
- Redirect has highest priority over stall and over any response:
  - IF/ID flushed: ifid_valid<=0, ifid_instr<=NOP_INSTR, ifid_pc4<=0.
  - pc<={redirect_pc[31:2],2'b00}. Hold buffer cleared.
  - If a response is still outstanding, set the kill flag and stay in S_WAIT; the next rvalid is dropped silently, then go to S_REQ.
  - Otherwise go to S_REQ. No imem_req is issued in the redirect cycle.
- Redirect in the same cycle as rvalid: response discarded, no kill flag set.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000.
- imem_req held with stable imem_addr until gnt (no retraction except on redirect or reset).
- Reset mid-transaction: all state cleared immediately. Any late rvalid after reset release with no outstanding request is ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] (IF/ID loads with valid=1), perf_stall_cyc[31:0] (cycles with ifid_valid && id_stall), and perf_flush[31:0] (redirects). All counters reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; functional behaviour identical.

Decomposition:
- Shared package mips_pkg: INSTR_W=32, ADDR_W=32, NOP_INSTR constant, fetch_state_t enum {S_REQ,S_WAIT,S_HOLD}, ifid_t struct {valid, pc4, instr} (reused by decode and hazard unit).
- One natural sub-module: ifid_reg, the IF/ID register with load/hold/flush priority (flush > hold > load).

Test Plan:
- Reset, gnt tied 1, rvalid 1 cycle after grant, memory holds instr=addr -> ifid_pc4 sequence 4,8,12,...; ifid_valid=1 every cycle from the 3rd edge.
- id_stall high 3 cycles while a response arrives -> ifid_* frozen; data parked in S_HOLD; no imem_req during hold; next instruction appears the cycle after stall drops; no duplicates or skips.
- redirect_valid with redirect_pc=32'h0000_0103 while in S_WAIT -> ifid_valid=0 next edge; pending response dropped; next imem_addr=32'h0000_0100.
- redirect and id_stall asserted together -> flush wins (ifid_valid=0, ifid_instr=NOP_INSTR).
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n pulsed low during S_WAIT with gnt delayed 2 cycles -> outputs at reset values asynchronously; first post-reset imem_addr=RESET_PC; stale rvalid ignored.
